// File: rtl/tpu_pkg.sv
// tpu_pkg: host opcodes, TPU memory map and sequencer states
package tpu_pkg;
  typedef enum logic [2:0] {
    LOAD_A = 3'd0,
    LOAD_B = 3'd1,
    LOAD_C = 3'd2,
    MATMUL = 3'd3,
    READ_C = 3'd4
  } op_e;
  typedef enum logic [2:0] {IDLE, WRITE, START, WAIT, READ} state_e;
  localparam logic [15:0] BASE_A  = 16'h0100;
  localparam logic [15:0] BASE_B  = 16'h0200;
  localparam logic [15:0] BASE_C  = 16'h0300;
  localparam logic [15:0] BASE_MM = 16'h0400;
endpackage

// File: rtl/tpu_out_reg.sv
// tpu_out_reg: one-entry valid/ready output register
module tpu_out_reg #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] d,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] q
);
  always_ff @(posedge clk)
    if (rst) begin
      valid <= 1'b0;
      q <= '0;
    end else begin
      valid <= load || (valid && !ready);
      if (load) q <= d;
    end
endmodule

// File: rtl/tpu_host_seq.sv
// tpu_host_seq: turns host opcodes and data beats into TPU MMIO accesses
module tpu_host_seq
  import tpu_pkg::*;
#(
  parameter int BITS_AB   = 8,
  parameter int BITS_C    = 16,
  parameter int DIM       = 8,
  parameter int ADDRW     = 16,
  parameter int DATAW     = 64,
  parameter int MM_CYCLES = 3*DIM
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic [DATAW-1:0] din_data,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic [DATAW-1:0] dout_data,
  output logic             busy,
  output logic [ADDRW-1:0] tpu_addr,
  output logic             tpu_r_w,
  output logic [DATAW-1:0] tpu_dataIn,
  input  logic [DATAW-1:0] tpu_dataOut
);
  localparam int AB_BEATS = DIM*DIM*BITS_AB/DATAW;
  localparam int C_BEATS  = DIM*DIM*BITS_C/DATAW;
  localparam int CW = $clog2(C_BEATS);
  localparam int WW = $clog2(MM_CYCLES+1);
  state_e state;
  op_e op, nop;
  logic [CW-1:0] cnt;
  logic [WW-1:0] wcnt;
  logic drain, cap, last, wr_beat;
  logic [ADDRW-1:0] base, off;
  assign nop = op_e'(cmd_op);
  assign cmd_ready = state == IDLE;
  assign busy = state != IDLE;
  assign din_ready = state == WRITE;
  assign wr_beat = state == WRITE && din_valid;
  assign cap = state == READ && !drain && (!dout_valid || dout_ready);
  assign last = cnt == CW'((op == LOAD_A || op == LOAD_B ? AB_BEATS : C_BEATS) - 1);
  // C rows are two consecutive beats, so every region advances one beat-width per count
  assign off = ADDRW'(cnt) * ADDRW'(DATAW/8);
  assign base = op == LOAD_A ? ADDRW'(BASE_A) : op == LOAD_B ? ADDRW'(BASE_B) : ADDRW'(BASE_C);
  assign tpu_r_w = wr_beat || state == START;
  assign tpu_addr = state == START ? ADDRW'(BASE_MM) :
                    (wr_beat || (state == READ && !drain)) ? base + off : '0;
  assign tpu_dataIn = state == WRITE ? din_data : '0;
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      op <= LOAD_A;
      cnt <= '0;
      wcnt <= '0;
      drain <= 1'b0;
    end else
      case (state)
        IDLE: if (cmd_valid) begin
          op <= nop;
          cnt <= '0;
          drain <= 1'b0;
          state <= nop inside {LOAD_A, LOAD_B, LOAD_C} ? WRITE :
                   nop == MATMUL ? START : nop == READ_C ? READ : IDLE;
        end
        WRITE: if (din_valid) begin
          cnt <= cnt + CW'(1);
          if (last) state <= IDLE;
        end
        START: begin
          wcnt <= '0;
          state <= WAIT;
        end
        WAIT: if (wcnt == WW'(MM_CYCLES-1)) state <= IDLE; else wcnt <= wcnt + WW'(1);
        READ: begin
          if (cap) begin
            cnt <= cnt + CW'(1);
            if (last) drain <= 1'b1;
          end
          if (drain && !dout_valid) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
  tpu_out_reg #(.W(DATAW)) u_out (
    .clk(clk),
    .rst(rst),
    .load(cap),
    .d(tpu_dataOut),
    .ready(dout_ready),
    .valid(dout_valid),
    .q(dout_data)
  );
endmodule

// File: tb/tb_tpu_host_seq.sv
// tb_tpu_host_seq: sequencer driven against a behavioural TPU and matrix reference
module tb_tpu_host_seq;
  logic clk = 1'b0, rst = 1'b1;
  logic cmd_valid = 1'b0, cmd_ready;
  logic [2:0] cmd_op = 3'd0;
  logic din_valid = 1'b0, din_ready;
  logic [63:0] din_data = '0;
  logic dout_valid, dout_ready = 1'b1;
  logic [63:0] dout_data;
  logic busy, tpu_r_w;
  logic [15:0] tpu_addr;
  logic [63:0] tpu_dataIn, tpu_dataOut;
  int n_cmp = 0, n_bad = 0, busy_cnt = 0;
  logic xor_mode = 1'b0;
  logic [79:0] wr_q[$];
  logic [63:0] rd_q[$];
  logic [63:0] src[16];
  logic [63:0] ma[8], mb[8], mc[16];
  logic [7:0] ra[8][8], rb[8][8];
  logic prev_v = 1'b0, prev_r = 1'b0;
  logic [63:0] prev_d = '0;
  typedef struct {logic [2:0] op; int nwr; logic [15:0] a0; int nrd; int bcyc;} vec_t;
  vec_t tv[7];

  tpu_host_seq dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .din_valid(din_valid), .din_ready(din_ready), .din_data(din_data),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_data(dout_data), .busy(busy),
    .tpu_addr(tpu_addr), .tpu_r_w(tpu_r_w), .tpu_dataIn(tpu_dataIn), .tpu_dataOut(tpu_dataOut)
  );

  always #5 clk = ~clk;

  always_comb tpu_dataOut = xor_mode ? {4{tpu_addr ^ 16'hA5A5}} :
                            tpu_addr[15:8] == 8'h03 ? mc[tpu_addr[6:3]] : 64'h0;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tpu_matmul();
    logic [15:0] s;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        s = '0;
        for (int k = 0; k < 8; k++) s += 16'(ma[i][8*k +: 8]) * 16'(mb[k][8*j +: 8]);
        mc[2*i + j/4][16*(j%4) +: 16] = s;
      end
  endtask

  function automatic logic [63:0] c_ref(input int b);
    logic [63:0] r;
    logic [15:0] s;
    r = '0;
    for (int jj = 0; jj < 4; jj++) begin
      s = '0;
      for (int k = 0; k < 8; k++) s += 16'(ra[b/2][k]) * 16'(rb[k][4*(b%2) + jj]);
      r[16*jj +: 16] = s;
    end
    return r;
  endfunction

  // TPU side effects, write/read logging and dout stability, sampled mid-cycle
  always begin
    @(negedge clk);
    #2;
    if (!rst) begin
      if (busy) busy_cnt++;
      if (din_ready === 1'b1) chk("rw_follows_valid", tpu_r_w, din_valid);
      if (prev_v === 1'b1 && prev_r === 1'b0) chk("dout_hold", {dout_valid, dout_data}, {1'b1, prev_d});
      if (dout_valid === 1'b1 && dout_ready) rd_q.push_back(dout_data);
    end
    if (tpu_r_w === 1'b1) begin
      wr_q.push_back({tpu_addr, tpu_dataIn});
      case (tpu_addr[15:8])
        8'h01: ma[tpu_addr[5:3]] = tpu_dataIn;
        8'h02: mb[tpu_addr[5:3]] = tpu_dataIn;
        8'h03: mc[tpu_addr[6:3]] = tpu_dataIn;
        8'h04: tpu_matmul();
        default: ;
      endcase
    end
    prev_v = rst ? 1'b0 : dout_valid;
    prev_r = dout_ready;
    prev_d = dout_data;
  end

  // vm: 0 continuous din_valid, 1 every other cycle, 2 random; rm: 0 ready, 1 three-cycle stall, 2 random
  task automatic run(input logic [2:0] op, input int vm, input int rm);
    int i, t;
    i = 0;
    t = 0;
    wr_q.delete();
    rd_q.delete();
    busy_cnt = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op = op;
    @(negedge clk);
    cmd_valid = 1'b0;
    while (busy && t < 400) begin
      din_valid = vm == 0 || (vm == 1 && t % 2 == 0) || (vm == 2 && $urandom_range(0, 1) == 1);
      din_data = src[i % 16];
      dout_ready = !(rm == 1 && t >= 4 && t < 7) && !(rm == 2 && $urandom_range(0, 2) == 0);
      #1 if (din_valid && din_ready) i++;
      @(negedge clk);
      t++;
    end
    din_valid = 1'b0;
    din_data = '0;
    dout_ready = 1'b1;
    if (t >= 400) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout op %0d: still busy after %0d cycles", op, t);
    end
  endtask

  task automatic chk_reset(input string name);
    chk(name, {cmd_ready, din_ready, dout_valid, busy, tpu_r_w, tpu_addr, tpu_dataIn, dout_data},
        {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 64'h0, 64'h0});
  endtask

  initial begin
    int bad;
    for (int i = 0; i < 16; i++) src[i] = 64'(16'h0101 * (i + 1));
    repeat (3) @(negedge clk);
    rst = 1'b0;
    din_data = 64'hDEAD;
    #1 chk_reset("reset_state");

    tv[0] = '{3'd0, 8, 16'h0100, 0, 8};
    tv[1] = '{3'd1, 8, 16'h0200, 0, 8};
    tv[2] = '{3'd2, 16, 16'h0300, 0, 16};
    tv[3] = '{3'd3, 1, 16'h0400, 0, 25};
    tv[4] = '{3'd4, 0, 16'h0300, 16, 18};
    tv[5] = '{3'd5, 0, 16'h0000, 0, 0};
    tv[6] = '{3'd7, 0, 16'h0000, 0, 0};
    xor_mode = 1'b1;
    for (int k = 0; k < 7; k++) begin
      run(tv[k].op, 0, 0);
      chk($sformatf("busy_cycles op%0d", tv[k].op), busy_cnt, tv[k].bcyc);
      chk($sformatf("n_writes op%0d", tv[k].op), wr_q.size(), tv[k].nwr);
      chk($sformatf("n_reads op%0d", tv[k].op), rd_q.size(), tv[k].nrd);
      for (int i = 0; i < tv[k].nwr && i < wr_q.size(); i++)
        chk($sformatf("write%0d op%0d", i, tv[k].op), wr_q[i],
            {16'(tv[k].a0 + 8*i), tv[k].op == 3'd3 ? 64'h0 : src[i]});
      for (int i = 0; i < tv[k].nrd && i < rd_q.size(); i++)
        chk($sformatf("read%0d op%0d", i, tv[k].op), rd_q[i], {4{16'(tv[k].a0 + 8*i) ^ 16'hA5A5}});
    end

    run(3'd1, 1, 0);
    chk("loadb_gaps_n", wr_q.size(), 8);
    for (int i = 0; i < wr_q.size(); i++) chk($sformatf("loadb_gap_wr%0d", i), wr_q[i], {16'(16'h0200 + 8*i), src[i]});

    run(3'd4, 0, 1);
    chk("read_stall_n", rd_q.size(), 16);
    for (int i = 0; i < rd_q.size(); i++)
      chk($sformatf("read_stall%0d", i), rd_q[i], {4{16'(16'h0300 + 8*i) ^ 16'hA5A5}});

    wr_q.delete();
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op = 3'd3;
    @(negedge clk);
    cmd_op = 3'd0;
    bad = 0;
    for (int c = 0; c < 25; c++) begin
      #1 if (cmd_ready !== 1'b0 || din_ready !== 1'b0) bad++;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    #1 chk("mm_window_blocked", bad, 0);
    chk("mm_ready_after", {cmd_ready, din_ready}, 2'b10);
    chk("mm_single_write", wr_q.size(), 1);
    chk("mm_write_addr", wr_q[0], {16'h0400, 64'h0});

    xor_mode = 1'b0;
    for (int r = 0; r < 8; r++) src[r] = 64'h1 << (8*r);
    run(3'd0, 0, 0);
    for (int r = 0; r < 8; r++) src[r] = 64'h0202020202020202;
    run(3'd1, 2, 0);
    run(3'd3, 0, 0);
    run(3'd4, 0, 2);
    chk("flow_n", rd_q.size(), 16);
    for (int i = 0; i < rd_q.size(); i++) chk($sformatf("flow_c%0d", i), rd_q[i], 64'h0002000200020002);

    for (int it = 0; it < 3; it++) begin
      for (int r = 0; r < 8; r++)
        for (int e = 0; e < 8; e++) begin
          ra[r][e] = 8'($urandom);
          rb[r][e] = 8'($urandom);
        end
      for (int r = 0; r < 8; r++) for (int e = 0; e < 8; e++) src[r][8*e +: 8] = ra[r][e];
      run(3'd0, 2, 0);
      for (int r = 0; r < 8; r++) for (int e = 0; e < 8; e++) src[r][8*e +: 8] = rb[r][e];
      run(3'd1, 2, 0);
      run(3'd3, 0, 0);
      run(3'd4, 0, 2);
      chk($sformatf("rand%0d_n", it), rd_q.size(), 16);
      for (int i = 0; i < rd_q.size(); i++) chk($sformatf("rand%0d_c%0d", it, i), rd_q[i], c_ref(i));
      for (int i = 0; i < 16; i++) src[i] = {$urandom, $urandom};
      run(3'd2, 2, 0);
      run(3'd4, 0, 2);
      chk($sformatf("rand%0d_ldc_n", it), rd_q.size(), 16);
      for (int i = 0; i < rd_q.size(); i++) chk($sformatf("rand%0d_ldc%0d", it, i), rd_q[i], src[i]);
    end

    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op = 3'd2;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int b = 0; b < 4; b++) begin
      din_valid = 1'b1;
      din_data = src[b];
      if (b == 3) rst = 1'b1;
      @(negedge clk);
    end
    rst = 1'b0;
    din_valid = 1'b0;
    din_data = 64'hBEEF;
    #1 chk_reset("reset_mid_loadc");
    run(3'd2, 0, 0);
    chk("loadc_restart_n", wr_q.size(), 16);
    chk("loadc_restart_addr", wr_q[0], {16'h0300, src[0]});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
